// File: rtl/fp64_cmp_arbiter_if.sv
// Request/response bundle for the shared FP64 comparator: NUM_REQ operand-pair
// channels in, one tagged flag response out, plus the completed-compare counter.
interface fp64_cmp_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*64-1:0] req_a;
  logic [NUM_REQ*64-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_eq;
  logic                  rsp_lt;
  logic                  rsp_gt;
  logic [15:0]           cmp_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt, cmp_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt, cmp_count
  );
endinterface

// File: rtl/fp64_cmp_arbiter.sv
// Round-robin front end sharing one combinational FP64 comparator: IDLE grants and
// latches an operand pair, CMP registers the flags, RESP holds them until accepted.
module fp64_cmp_arbiter #(
  parameter int NUM_REQ = 4
) (
  input logic                  clk,
  input logic                  rst,
  fp64_cmp_arbiter_if.slave    bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    op_id_q;
  logic [63:0]        op_a_q, op_b_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic               eq_q, lt_q, gt_q;
  logic [15:0]        cmp_count_q;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W:0]      scan_sum;
  logic [ID_W-1:0]    scan_idx;
  logic [63:0]        win_a, win_b;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               grant, accept;
  logic               cmp_eq, cmp_lt, cmp_gt;

  // Returns {eq, lt, gt}. Any NaN/Inf operand raises all three flags; any
  // zero/subnormal operand clears all three.
  function automatic logic [2:0] fp64_cmp(input logic [63:0] a, input logic [63:0] b);
    logic mag_gt;
    if (a[62:52] == 11'h7FF || b[62:52] == 11'h7FF) return 3'b111;
    if (a[62:52] == 11'h000 || b[62:52] == 11'h000) return 3'b000;
    if (a == b) return 3'b100;
    if (a[63] != b[63]) return a[63] ? 3'b010 : 3'b001;
    mag_gt = (a[62:0] > b[62:0]);
    if (a[63]) return mag_gt ? 3'b010 : 3'b001;
    return mag_gt ? 3'b001 : 3'b010;
  endfunction

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      scan_idx = scan_sum[ID_W-1:0];
      if (!win_found && bus.req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == win_id) begin
        win_a = bus.req_a[64*j +: 64];
        win_b = bus.req_b[64*j +: 64];
      end
    end
  end

  always_comb begin
    {cmp_eq, cmp_lt, cmp_gt} = fp64_cmp(op_a_q, op_b_q);
  end

  always_comb begin
    state_d     = state_q;
    req_ready_c = '0;
    grant       = 1'b0;
    accept      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Grant is suppressed during the reset cycle so nothing is handshaken away.
        if (win_found && !rst) begin
          req_ready_c[win_id] = 1'b1;
          grant               = 1'b1;
          state_d             = S_CMP;
        end
      end
      S_CMP:  state_d = S_RESP;
      S_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          accept  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      // NOTE: the operand registers are cleared too, so nothing stale from an
      // aborted transaction can reach the comparator output.
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      cmp_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        op_a_q  <= win_a;
        op_b_q  <= win_b;
        op_id_q <= win_id;
      end
      if (state_q == S_CMP) begin
        eq_q        <= cmp_eq;
        lt_q        <= cmp_lt;
        gt_q        <= cmp_gt;
        rsp_id_q    <= op_id_q;
        rsp_valid_q <= 1'b1;
      end
      if (accept) begin
        rsp_valid_q <= 1'b0;
        cmp_count_q <= cmp_count_q + 16'd1;
        rr_ptr_q    <= (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_eq    = eq_q;
  assign bus.rsp_lt    = lt_q;
  assign bus.rsp_gt    = gt_q;
  assign bus.cmp_count = cmp_count_q;
endmodule
